instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEM_SEL, default 4'h1: instruction-memory select code, driven on address[15:12].
REQ-002 Parameter PROG_LEN, default 13: number of valid instruction words; the legal pc range is 0..PROG_LEN-1.
REQ-003 Clk input 1: single system clock; all state changes on rising edge.
REQ-004 Reset input 1: asynchronous, active-high reset.
REQ-005 start input 1: one-cycle pulse that begins fetching from pc 0.
REQ-006 redirect input 1: one-cycle pulse that loads redirect_pc as the next fetch address.
REQ-007 redirect_pc input 12: redirect target word address.
REQ-008 instr_ready input 1: consumer (decoder) accepts instr when high with instr_valid.
REQ-009 address output 16: system address bus, {MEM_SEL, pc}.
REQ-010 nRead output 1: active-low read strobe to the system bus.
REQ-011 DataBus inout 256: shared system bus; this block SHALL only sample it and SHALL drive it to high-Z at all times.
REQ-012 instr output 32: fetched instruction word, DataBus[31:0] as captured.
REQ-013 instr_valid output 1: instr holds a word not yet accepted.
REQ-014 pc_out output 12: word address of the word currently in instr.
REQ-015 halted output 1: fetch has stopped; only start or Reset resumes it.
REQ-016 busy output 1: a bus read is in progress (state REQ or WAIT).

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, VALID and HALT.
REQ-018 IDLE -> REQ on start; pc SHALL load 0.
REQ-019 REQ drives address={MEM_SEL,pc} and nRead=0; it SHALL always advance to WAIT after one cycle.
REQ-020 WAIT keeps address and nRead=0 unchanged; on the WAIT->VALID edge DataBus[31:0] SHALL be captured into instr, and pc_out SHALL load pc.
REQ-021 Fetch latency SHALL be exactly 2 cycles from entering REQ to instr_valid=1; nRead SHALL be low for exactly those 2 cycles and high in every other state.
REQ-022 In VALID, instr and pc_out SHALL hold stable until instr_valid && instr_ready.
REQ-023 On acceptance: pc increments by 1; if the new pc == PROG_LEN -> HALT, else -> REQ (no idle cycle).
REQ-024 redirect in REQ or WAIT SHALL abort the read: no capture, pc<=redirect_pc, next state REQ (nRead may stay low across the restart).
REQ-025 redirect in VALID SHALL drop instr_valid the next cycle, discard instr, load pc<=redirect_pc and go to REQ; simultaneous instr_ready is honoured first (word consumed), then the redirect applies.
REQ-026 A redirect_pc >= PROG_LEN SHALL go directly to HALT without a bus read.
REQ-027 redirect in IDLE or HALT SHALL be ignored; start in any state other than IDLE/HALT SHALL be ignored.
REQ-028 start in HALT SHALL clear halted and behave as in IDLE.
REQ-029 halted=1 exactly while in HALT; busy=1 exactly while in REQ or WAIT.
REQ-030 pc arithmetic SHALL be 12-bit unsigned; no wrap occurs, because HALT is reached at PROG_LEN.

Reset
REQ-031 Reset SHALL force IDLE immediately: pc=0, address=16'h0000, nRead=1, instr=0, instr_valid=0, pc_out=0, halted=0, busy=0.
REQ-032 Reset mid-read SHALL release nRead within the same cycle and discard the pending word.

Configuration
REQ-033 Macro FETCH_HALT_ON_STOP_EN: when defined, a captured word with instr[31:24]==8'hFF is delivered normally and, on its acceptance, the FSM enters HALT instead of fetching again.
REQ-034 Without FETCH_HALT_ON_STOP_EN, opcode 8'hFF SHALL get no special treatment; only PROG_LEN ends fetching.

Verification
REQ-035 Start with memory words 0..12 = 32'h0100_0000+i and instr_ready held 1 -> 13 words delivered in order, one every 3 cycles, pc_out 0..12, then halted=1 and nRead=1.
REQ-036 instr_ready=0 for 5 cycles after the first word -> instr=32'h0100_0000 and pc_out=0 stable, nRead=1, no new address issued.
REQ-037 Redirect to pc 7 during WAIT of fetch 2 -> no word for pc 2 is delivered, next delivered pc_out=7.
REQ-038 Redirect to 12'd20 with PROG_LEN=13 -> HALT, no nRead pulse.
REQ-039 Reset asserted during WAIT -> nRead=1 and instr_valid=0 immediately; start afterwards refetches pc 0.
REQ-040 With FETCH_HALT_ON_STOP_EN defined and word 4 = 32'hFF00_0000 -> halted after word 4 is accepted; without the macro, words 5..12 follow.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Handshake bundle between instruction_fetch, its sequencer and the decoder.
// The fetch block uses the slave modport.
interface instruction_fetch_if;
  logic        start;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        instr_ready;
  logic [15:0] address;
  logic        nRead;
  logic [31:0] instr;
  logic        instr_valid;
  logic [11:0] pc_out;
  logic        halted;
  logic        busy;

  modport master (
    output start, redirect, redirect_pc, instr_ready,
    input  address, nRead, instr, instr_valid, pc_out, halted, busy
  );

  modport slave (
    input  start, redirect, redirect_pc, instr_ready,
    output address, nRead, instr, instr_valid, pc_out, halted, busy
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: two-cycle bus read per word, valid/ready hand-off to the decoder.
// Optional macro FETCH_HALT_ON_STOP_EN halts fetching after an accepted 8'hFF opcode.
module instruction_fetch #(
  parameter logic [3:0]  MEM_SEL  = 4'h1,
  parameter int unsigned PROG_LEN = 13
) (
  input  logic                Clk,
  input  logic                Reset,
  instruction_fetch_if.slave  fif,
  inout  wire  [255:0]        DataBus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, HALT} state_t;

  localparam logic [11:0] PC_END = 12'(PROG_LEN);

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic [11:0] pc_inc;
  logic        busy;
  logic        stop_hit;
  logic        unused_bus_hi;

  // This block only listens to the shared bus.
  assign DataBus       = {256{1'bz}};
  assign unused_bus_hi = ^DataBus[255:32];

`ifdef FETCH_HALT_ON_STOP_EN
  assign stop_hit = (instr_q[31:24] == 8'hFF);
`else
  assign stop_hit = 1'b0;
`endif

  function automatic state_t redirect_state(input logic [11:0] target);
    return (target >= PC_END) ? HALT : REQ;
  endfunction

  assign pc_inc = pc_q + 12'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    case (state_q)
      IDLE, HALT: begin
        if (fif.start) begin
          state_d = REQ;
          pc_d    = 12'd0;
        end
      end
      REQ, WAIT: begin
        if (fif.redirect) begin
          pc_d    = fif.redirect_pc;
          state_d = redirect_state(fif.redirect_pc);
        end else if (state_q == REQ) begin
          state_d = WAIT;
        end else begin
          state_d  = VALID;
          instr_d  = DataBus[31:0];
          pc_out_d = pc_q;
        end
      end
      VALID: begin
        // A simultaneous accept consumes the word; the redirect target still wins.
        if (fif.redirect) begin
          pc_d    = fif.redirect_pc;
          state_d = redirect_state(fif.redirect_pc);
        end else if (fif.instr_ready) begin
          pc_d    = pc_inc;
          state_d = (pc_inc == PC_END || stop_hit) ? HALT : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      pc_q     <= 12'd0;
      pc_out_q <= 12'd0;
      instr_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
    end
  end

  // Bus strobes come straight off the state register so reset releases them at once.
  assign busy            = (state_q == REQ) || (state_q == WAIT);
  assign fif.busy        = busy;
  assign fif.nRead       = ~busy;
  assign fif.address     = busy ? {MEM_SEL, pc_q} : 16'h0000;
  assign fif.instr       = instr_q;
  assign fif.instr_valid = (state_q == VALID);
  assign fif.pc_out      = pc_out_q;
  assign fif.halted      = (state_q == HALT);
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a transaction-level fetch model,
// plus directed scenarios with literal expectations.
module tb_instruction_fetch;
  localparam logic [3:0] MEM_SEL  = 4'h1;
  localparam int         PROG_LEN = 13;
`ifdef FETCH_HALT_ON_STOP_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  instruction_fetch_if fif();
  wire  [255:0] DataBus;

  logic [31:0]  mem [0:4095];
  logic [223:0] bus_hi;
  logic [31:0]  bus_word;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          acc_pc   [$];
  logic [31:0] acc_word [$];
  int          acc_cyc  [$];

  instruction_fetch #(.MEM_SEL(MEM_SEL), .PROG_LEN(PROG_LEN)) dut (
    .Clk(Clk), .Reset(Reset), .fif(fif), .DataBus(DataBus)
  );

  // Memory answers only its own select code.
  assign bus_word = (fif.address[15:12] == MEM_SEL) ? mem[fif.address[11:0]] : 32'hDEAD_BEEF;
  assign DataBus  = {bus_hi, bus_word};

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a read takes two bus cycles, a delivered word waits for ready.
  bit          m_run = 0, m_halt = 0, m_have = 0, m_age = 0;
  logic [11:0] m_pc = '0, m_wpc = '0;
  logic [31:0] m_word = '0;

  function automatic bit stop_opcode(input logic [31:0] w);
    return STOP_EN && (w[31:24] == 8'hFF);
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_run <= 0; m_halt <= 0; m_have <= 0; m_age <= 0;
      m_pc <= '0; m_wpc <= '0; m_word <= '0;
    end else begin
      bit          n_run, n_halt, n_have, n_age;
      logic [11:0] n_pc, n_wpc;
      logic [31:0] n_word;
      n_run = m_run; n_halt = m_halt; n_have = m_have; n_age = m_age;
      n_pc = m_pc; n_wpc = m_wpc; n_word = m_word;
      if (!m_run) begin
        if (fif.start) begin
          n_run = 1; n_halt = 0; n_have = 0; n_age = 0; n_pc = '0;
        end
      end else if (m_have) begin
        if (fif.instr_ready) begin
          n_have = 0; n_age = 0;
          n_pc = m_pc + 12'd1;
          if (int'(n_pc) == PROG_LEN || stop_opcode(m_word)) begin n_run = 0; n_halt = 1; end
        end
        if (fif.redirect) begin
          n_have = 0; n_age = 0;
          n_pc = fif.redirect_pc;
          n_run = (int'(fif.redirect_pc) < PROG_LEN);
          n_halt = !n_run;
        end
      end else begin
        if (fif.redirect) begin
          n_age = 0;
          n_pc = fif.redirect_pc;
          n_run = (int'(fif.redirect_pc) < PROG_LEN);
          n_halt = !n_run;
        end else if (!m_age) begin
          n_age = 1;
        end else begin
          n_word = mem[m_pc]; n_wpc = m_pc; n_have = 1;
        end
      end
      m_run <= n_run; m_halt <= n_halt; m_have <= n_have; m_age <= n_age;
      m_pc <= n_pc; m_wpc <= n_wpc; m_word <= n_word;
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted words.
  always @(negedge Clk) begin
    bit e_busy;
    e_busy = m_run && !m_have;
    chk("busy", {31'd0, fif.busy}, {31'd0, e_busy});
    chk("nRead", {31'd0, fif.nRead}, {31'd0, !e_busy});
    chk("halted", {31'd0, fif.halted}, {31'd0, m_halt});
    chk("instr_valid", {31'd0, fif.instr_valid}, {31'd0, m_have});
    if (e_busy) chk("address", {16'd0, fif.address}, {16'd0, MEM_SEL, m_pc});
    if (m_have) begin
      chk("instr", fif.instr, m_word);
      chk("pc_out", {20'd0, fif.pc_out}, {20'd0, m_wpc});
    end
    if (fif.instr_valid && fif.instr_ready && !Reset) begin
      acc_pc.push_back(int'(fif.pc_out));
      acc_word.push_back(fif.instr);
      acc_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic pulse_start();
    fif.start = 1'b1; tick(); fif.start = 1'b0;
  endtask

  task automatic do_reset();
    fif.start = 1'b0; fif.redirect = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    acc_pc.delete(); acc_word.delete(); acc_cyc.delete();
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!fif.halted && n < 80) begin tick(); n++; end
    chk(name, {31'd0, fif.halted}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen2;
    fif.start = 1'b0; fif.redirect = 1'b0; fif.redirect_pc = '0; fif.instr_ready = 1'b1;
    bus_hi = {7{$urandom()}};
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0100_0000 + i;
    repeat (2) tick();

    chk("rst_address", {16'd0, fif.address}, 32'h0000_0000);
    chk("rst_nRead", {31'd0, fif.nRead}, 32'd1);
    chk("rst_instr", fif.instr, 32'd0);
    chk("rst_valid", {31'd0, fif.instr_valid}, 32'd0);
    chk("rst_pc_out", {20'd0, fif.pc_out}, 32'd0);
    chk("rst_halted", {31'd0, fif.halted}, 32'd0);
    chk("rst_busy", {31'd0, fif.busy}, 32'd0);
    Reset = 1'b0;
    acc_pc.delete(); acc_word.delete(); acc_cyc.delete();

    // Straight run of 13 words with the decoder always ready.
    fif.instr_ready = 1'b1;
    pulse_start();
    wait_halted("run_halted");
    chk("run_nRead", {31'd0, fif.nRead}, 32'd1);
    chk("run_count", acc_pc.size(), 32'd13);
    for (int i = 0; i < acc_pc.size() && i < 13; i++) begin
      chk("run_pc_out", acc_pc[i], i);
      chk("run_word", acc_word[i], 32'h0100_0000 + i);
      if (i > 0) chk("run_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd3);
    end

    // Decoder stalls after the first word.
    do_reset();
    fif.instr_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!fif.instr_valid && n < 10) begin tick(); n++; end
    chk("stall_first_valid", {31'd0, fif.instr_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", fif.instr, 32'h0100_0000);
      chk("stall_pc_out", {20'd0, fif.pc_out}, 32'd0);
      chk("stall_nRead", {31'd0, fif.nRead}, 32'd1);
    end
    fif.instr_ready = 1'b1;
    wait_halted("stall_halted");

    // Redirect to 7 while fetch 2 is waiting on the bus.
    do_reset();
    pulse_start();
    n = 0;
    while (!(fif.nRead == 1'b0 && fif.address == {MEM_SEL, 12'd2}) && n < 20) begin tick(); n++; end
    tick();
    fif.redirect = 1'b1; fif.redirect_pc = 12'd7;
    tick();
    fif.redirect = 1'b0;
    wait_halted("redir_halted");
    seen2 = 0;
    foreach (acc_pc[i]) if (acc_pc[i] == 2) seen2 = 1;
    chk("redir_no_pc2", {31'd0, seen2}, 32'd0);
    chk("redir_count", acc_pc.size(), 32'd8);
    if (acc_pc.size() > 2) chk("redir_next_pc", acc_pc[2], 32'd7);

    // Out-of-range redirect from VALID halts without another read.
    do_reset();
    fif.instr_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!fif.instr_valid && n < 10) begin tick(); n++; end
    fif.redirect = 1'b1; fif.redirect_pc = 12'd20;
    tick();
    fif.redirect = 1'b0;
    chk("oob_halted", {31'd0, fif.halted}, 32'd1);
    chk("oob_valid", {31'd0, fif.instr_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("oob_nRead", {31'd0, fif.nRead}, 32'd1);
    end
    fif.instr_ready = 1'b1;

    // Asynchronous reset in the middle of a read.
    do_reset();
    pulse_start();
    tick();
    #2 Reset = 1'b1;
    #1;
    chk("arst_nRead", {31'd0, fif.nRead}, 32'd1);
    chk("arst_valid", {31'd0, fif.instr_valid}, 32'd0);
    chk("arst_busy", {31'd0, fif.busy}, 32'd0);
    tick();
    Reset = 1'b0;
    acc_pc.delete(); acc_word.delete(); acc_cyc.delete();
    pulse_start();
    n = 0;
    while (acc_pc.size() == 0 && n < 10) begin tick(); n++; end
    chk("arst_refetch_count", {31'd0, acc_pc.size() > 0}, 32'd1);
    if (acc_pc.size() > 0) begin
      chk("arst_refetch_pc", acc_pc[0], 32'd0);
      chk("arst_refetch_word", acc_word[0], 32'h0100_0000);
    end

    // Stop opcode at word 4.
    do_reset();
    mem[4] = 32'hFF00_0000;
    pulse_start();
    wait_halted("stop_halted");
    chk("stop_count", acc_pc.size(), STOP_EN ? 32'd5 : 32'd13);
    if (acc_pc.size() > 4) chk("stop_word4", acc_word[4], 32'hFF00_0000);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 32; i++) mem[i] = $urandom();
    mem[3] = {8'hFF, mem[3][23:0]};
    for (int i = 0; i < 3000; i++) begin
      fif.start       = ($urandom_range(0, 7) == 0);
      fif.redirect    = ($urandom_range(0, 9) == 0);
      fif.redirect_pc = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(13, 40))
                                                   : 12'($urandom_range(0, 12));
      fif.instr_ready = ($urandom_range(0, 2) != 0);
      Reset           = ($urandom_range(0, 299) == 0);
      tick();
    end
    Reset = 1'b0;
    fif.start = 1'b0; fif.redirect = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
